// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler.
//   - Lamp encodings driven on each approach output (one-hot, 3 bits).
//   - Approach indices used for req/grant bit positions.
//   - Controller state enumeration.
//   - app_onehot(): approach index -> one-hot grant vector.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [1:0] APP_M1 = 2'd0;
    localparam logic [1:0] APP_M2 = 2'd1;
    localparam logic [1:0] APP_MT = 2'd2;
    localparam logic [1:0] APP_SR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_ALLRED = 3'd3,
        ST_EMG    = 3'd4
    } state_e;

    function automatic logic [3:0] app_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker, purely combinational.
// Ports:
//   req    [3:0] in  : demand bits, one per approach
//   last   [1:0] in  : index granted most recently
//   winner [1:0] out : first asserted req strictly after last, wrapping 3->0
//                      (last itself is the final candidate)
//   valid        out : at least one req bit is set
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] w_idx;

    // Scan from the farthest candidate back to the nearest so that the
    // closest asserted index after 'last' is the one left standing.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        w_idx  = last;
        for (int k = 4; k >= 1; k--) begin
            w_idx = last + 2'(k);
            if (req[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler with emergency preemption.
// Durations are counted in 'tick' pulses, not clock cycles.
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset (forces all red at once)
//   tick         in  : one-cycle timing enable
//   req    [3:0] in  : level demand, bit0=M1 bit1=M2 bit2=MT bit3=SR
//   emg_req      in  : level emergency preemption request
//   emg_dir[1:0] in  : emergency approach, sampled only while emg_req=1
//   M1,M2,MT,SR  out : registered lamps (001 green, 010 yellow, 100 red)
//   grant  [3:0] out : one-hot approach currently green or yellow
//   emg_active   out : high while the emergency green is displayed
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 7,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    output logic [2:0] M1,
    output logic [2:0] M2,
    output logic [2:0] MT,
    output logic [2:0] SR,
    output logic [3:0] grant,
    output logic       emg_active
);

    localparam logic [3:0] C_G_LAST = 4'(GREEN_T - 1);
    localparam logic [3:0] C_Y_LAST = 4'(YELLOW_T - 1);
    localparam logic [3:0] C_A_LAST = 4'(ALLRED_T - 1);

    state_e           r_state;
    logic [3:0]       r_cnt;
    logic [1:0]       r_last;
    logic [3:0][2:0]  r_lamps;
    logic [3:0]       r_grant;
    logic             r_emg;

    state_e           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [1:0]       w_last_nxt;
    logic [3:0][2:0]  w_lamps_nxt;
    logic [3:0]       w_grant_nxt;
    logic             w_emg_nxt;
    logic [1:0]       w_rr_winner;
    logic             w_rr_valid;
    logic             w_req_other;

    rr_arbiter4 u_rr (
        .req    (req),
        .last   (r_last),
        .winner (w_rr_winner),
        .valid  (w_rr_valid)
    );

    // r_last doubles as the index of the approach currently green/yellow.
    assign w_req_other = |(req & ~app_onehot(r_last));

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;

        unique case (r_state)
            ST_IDLE: begin
                if (emg_req) begin
                    w_state_nxt = ST_EMG;
                    w_last_nxt  = emg_dir;
                end else if (w_rr_valid) begin
                    w_state_nxt = ST_GREEN;
                    w_last_nxt  = w_rr_winner;
                end
            end
            ST_GREEN: begin
                // Preemption overrides the minimum green; a matching
                // direction is promoted to EMG without any lamp change.
                if (emg_req) begin
                    w_state_nxt = (emg_dir == r_last) ? ST_EMG : ST_YELLOW;
                end else if (tick && (r_cnt == C_G_LAST) && w_req_other) begin
                    w_state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tick && (r_cnt == C_Y_LAST)) begin
                    w_state_nxt = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (tick && (r_cnt == C_A_LAST)) begin
                    if (emg_req) begin
                        w_state_nxt = ST_EMG;
                        w_last_nxt  = emg_dir;
                    end else if (w_rr_valid) begin
                        w_state_nxt = ST_GREEN;
                        w_last_nxt  = w_rr_winner;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EMG: begin
                // Direction is latched on entry; later emg_dir changes are ignored.
                if (!emg_req) begin
                    w_state_nxt = ST_YELLOW;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter clears on every state change; in GREEN it saturates so the
    // phase can hold indefinitely until a competitor appears.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 4'd0;
        end else if (tick) begin
            if ((r_state == ST_YELLOW) || (r_state == ST_ALLRED) ||
                ((r_state == ST_GREEN) && (r_cnt != C_G_LAST))) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end
    end

    // Lamps are decoded from the next state so they register on the same
    // edge as the state itself.
    always_comb begin
        w_lamps_nxt = {4{RED}};
        w_grant_nxt = 4'b0000;
        w_emg_nxt   = 1'b0;
        unique case (w_state_nxt)
            ST_GREEN, ST_EMG: begin
                w_lamps_nxt[w_last_nxt] = GRN;
                w_grant_nxt             = app_onehot(w_last_nxt);
                w_emg_nxt               = (w_state_nxt == ST_EMG);
            end
            ST_YELLOW: begin
                w_lamps_nxt[w_last_nxt] = YEL;
                w_grant_nxt             = app_onehot(w_last_nxt);
            end
            default: begin
                w_lamps_nxt = {4{RED}};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= APP_SR;
            r_lamps <= {4{RED}};
            r_grant <= 4'b0000;
            r_emg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_lamps <= w_lamps_nxt;
            r_grant <= w_grant_nxt;
            r_emg   <= w_emg_nxt;
        end
    end

    assign M1         = r_lamps[APP_M1];
    assign M2         = r_lamps[APP_M2];
    assign MT         = r_lamps[APP_MT];
    assign SR         = r_lamps[APP_SR];
    assign grant      = r_grant;
    assign emg_active = r_emg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
`timescale 1ns/1ps
module tb_traffic_phase_scheduler;

    localparam int GT = 7;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       emg_req = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic [2:0] M1, M2, MT, SR;
    logic [3:0] grant;
    logic       emg_active;

    int checks = 0;
    int failures = 0;
    int tick_seen = 0;
    bit tick_en = 1'b0;

    traffic_phase_scheduler #(.GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
        .emg_req(emg_req), .emg_dir(emg_dir),
        .M1(M1), .M2(M2), .MT(MT), .SR(SR),
        .grant(grant), .emg_active(emg_active)
    );

    always #5 clk = ~clk;

    // Tick pulse once every 4 clocks while enabled.
    initial begin
        int tc = 0;
        forever begin
            @(negedge clk);
            tick = tick_en && (tc == 3);
            tc = (tc + 1) % 4;
        end
    end

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_GREEN, P_YELLOW, P_ALLRED, P_EMG} phase_t;
    phase_t m_ph = P_IDLE;
    int m_app = 0;
    int m_last = 3;
    int m_el = 0;   // ticks elapsed in current phase (unbounded)

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_app = 0; m_last = 3; m_el = 0;
        end else begin
            phase_t nph;
            int napp;
            bit others;
            if (tick) tick_seen++;
            nph = m_ph;
            napp = m_app;
            others = (req & ~(4'b0001 << m_app)) != 4'b0000;
            case (m_ph)
                P_IDLE: begin
                    if (emg_req) begin nph = P_EMG; napp = int'(emg_dir); end
                    else if (req != 4'b0000) begin nph = P_GREEN; napp = rr_pick(req, m_last); end
                end
                P_GREEN: begin
                    if (emg_req && int'(emg_dir) != m_app) nph = P_YELLOW;
                    else if (emg_req) nph = P_EMG;
                    else if (tick && (m_el + 1 >= GT) && others) nph = P_YELLOW;
                end
                P_YELLOW: if (tick && (m_el + 1 == YT)) nph = P_ALLRED;
                P_ALLRED: begin
                    if (tick && (m_el + 1 == AT)) begin
                        if (emg_req) begin nph = P_EMG; napp = int'(emg_dir); end
                        else if (req != 4'b0000) begin nph = P_GREEN; napp = rr_pick(req, m_last); end
                        else nph = P_IDLE;
                    end
                end
                P_EMG: if (!emg_req) nph = P_YELLOW;
                default: nph = P_IDLE;
            endcase
            if ((nph == P_GREEN || nph == P_EMG) && nph != m_ph) m_last = napp;
            if (nph != m_ph) m_el = 0;
            else if (tick) m_el++;
            m_ph = nph;
            m_app = napp;
        end
    end

    function automatic logic [2:0] exp_lamp(input int a);
        if (!rst_n) return L_RED;
        if ((m_ph == P_GREEN || m_ph == P_EMG) && m_app == a) return L_GRN;
        if (m_ph == P_YELLOW && m_app == a) return L_YEL;
        return L_RED;
    endfunction

    function automatic logic [3:0] exp_grant();
        if (!rst_n) return 4'b0000;
        if (m_ph == P_GREEN || m_ph == P_EMG || m_ph == P_YELLOW) return 4'b0001 << m_app;
        return 4'b0000;
    endfunction

    function automatic logic [2:0] dut_lamp(input int a);
        case (a)
            0: return M1;
            1: return M2;
            2: return MT;
            3: return SR;
            default: return L_RED;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            int nonred;
            @(negedge clk);
            nonred = 0;
            for (int a = 0; a < 4; a++) begin
                chk($sformatf("model_lamp%0d", a), dut_lamp(a), exp_lamp(a));
                if (dut_lamp(a) !== L_RED) nonred++;
            end
            chk("model_grant", grant, exp_grant());
            chk("model_emg", emg_active, (rst_n && m_ph == P_EMG) ? 1 : 0);
            chk("one_nonred", (nonred <= 1) ? 1 : 0, 1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting t=%0t", name, $time);
    endtask

    task automatic wait_lamp(input int a, input logic [2:0] v, input int maxc, input string name);
        int n = 0;
        while (dut_lamp(a) !== v && n < maxc) begin @(negedge clk); n++; end
        if (dut_lamp(a) !== v) timeout_fail(name);
    endtask

    task automatic wait_any_green(output int idx, input int maxc, input string name);
        int n = 0;
        idx = -1;
        while (n < maxc) begin
            for (int a = 0; a < 4; a++) if (dut_lamp(a) === L_GRN) idx = a;
            if (idx >= 0) break;
            @(negedge clk);
            n++;
        end
        if (idx < 0) timeout_fail(name);
    endtask

    task automatic wait_tick_count(input int target, input int maxc, input string name);
        int n = 0;
        while (tick_seen < target && n < maxc) begin @(negedge clk); n++; end
        if (tick_seen < target) timeout_fail(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 4'b0000; emg_req = 1'b0; emg_dir = 2'd0;
        tk(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int idx;
        int ord[5] = '{0, 1, 2, 3, 0};

        tick_en = 1'b1;
        tk(3);
        chk("rst_M1", M1, L_RED);
        chk("rst_M2", M2, L_RED);
        chk("rst_MT", MT, L_RED);
        chk("rst_SR", SR, L_RED);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_emg", emg_active, 1'b0);
        rst_n = 1'b1;

        // Single demand holds green, competitor forces a change.
        req = 4'b0001;
        tk(2);
        chk("s1_m1_green", M1, L_GRN);
        chk("s1_grant", grant, 4'b0001);
        tk(60);
        chk("s1_hold", M1, L_GRN);
        req = 4'b0011;
        t0 = tick_seen;
        wait_lamp(0, L_YEL, 8, "s1_to_yel");
        chk("s1_yel_after_one_tick", tick_seen - t0, 1);
        chk("s1_yel_grant", grant, 4'b0001);
        t0 = tick_seen;
        wait_lamp(1, L_GRN, 30, "s1_m2");
        chk("s1_clear_ticks", tick_seen - t0, 3);
        chk("s1_m2_grant", grant, 4'b0010);

        // All demands: round-robin order, 7-tick greens.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_any_green(idx, 40, "s2_green");
            chk($sformatf("s2_order%0d", g), idx, ord[g]);
            if (idx >= 0) begin
                t0 = tick_seen;
                wait_lamp(idx, L_YEL, 40, "s2_green_end");
                chk($sformatf("s2_green_ticks%0d", g), tick_seen - t0, 7);
            end
        end

        // Emergency to a different approach during green.
        do_reset();
        req = 4'b0001;
        wait_lamp(0, L_GRN, 10, "s3_m1");
        t0 = tick_seen;
        wait_tick_count(t0 + 2, 20, "s3_count2");
        emg_dir = 2'd2;
        emg_req = 1'b1;
        tk(1);
        chk("s3_m1_yel", M1, L_YEL);
        chk("s3_emg_not_yet", emg_active, 1'b0);
        t0 = tick_seen;
        wait_lamp(2, L_GRN, 30, "s3_mt_emg");
        chk("s3_clear_ticks", tick_seen - t0, 3);
        chk("s3_emg_active", emg_active, 1'b1);
        chk("s3_grant", grant, 4'b0100);
        tk(20);
        chk("s3_emg_hold", MT, L_GRN);
        emg_req = 1'b0;
        tk(1);
        chk("s3_mt_yel", MT, L_YEL);
        chk("s3_emg_off", emg_active, 1'b0);

        // Emergency matching the current green, dir change ignored.
        do_reset();
        req = 4'b0100;
        wait_lamp(2, L_GRN, 10, "s4_mt");
        emg_dir = 2'd2;
        emg_req = 1'b1;
        tk(1);
        chk("s4_mt_still_green", MT, L_GRN);
        chk("s4_emg_active", emg_active, 1'b1);
        emg_dir = 2'd0;
        tk(12);
        chk("s4_mt_after_dir", MT, L_GRN);
        chk("s4_m1_red", M1, L_RED);
        emg_req = 1'b0;
        tk(1);
        chk("s4_mt_yel", MT, L_YEL);

        // Asynchronous reset during yellow.
        do_reset();
        req = 4'b0011;
        wait_lamp(0, L_YEL, 40, "s5_yel");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_async_M1", M1, L_RED);
        chk("s5_async_grant", grant, 4'b0000);
        @(negedge clk);
        req = 4'b0000;
        rst_n = 1'b1;
        tk(3);
        chk("s5_idle_M1", M1, L_RED);
        chk("s5_idle_MT", MT, L_RED);
        chk("s5_idle_grant", grant, 4'b0000);
        req = 4'b0100;
        tk(1);
        chk("s5_mt_green", MT, L_GRN);

        // No ticks: nothing moves despite a competitor.
        tick_en = 1'b0;
        tk(1);
        req = 4'b0101;
        tk(50);
        chk("s6_frozen", MT, L_GRN);
        chk("s6_grant", grant, 4'b0100);
        tick_en = 1'b1;
        wait_lamp(2, L_YEL, 40, "s6_resume");

        tk(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_T, default 7: minimum green duration, in tick pulses.
REQ-002 Parameter YELLOW_T, default 2: yellow duration, in tick pulses.
REQ-003 Parameter ALLRED_T, default 1: all-red clearance duration, in tick pulses.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-cycle timing enable; all durations count tick pulses, not clk cycles.
REQ-007 req  input  4  level vehicle/pedestrian demand; bit0=M1, bit1=M2, bit2=MT, bit3=SR.
REQ-008 emg_req  input  1  level emergency preemption request.
REQ-009 emg_dir  input  2  approach index for emergency; sampled only while emg_req=1.
REQ-010 M1, M2, MT, SR  output  3 each  registered lamps; 001=green, 010=yellow, 100=red.
REQ-011 grant  output  4  one-hot of the approach currently green or yellow; 0 otherwise.
REQ-012 emg_active  output  1  high while an emergency green is displayed.

Function
REQ-013 States SHALL be IDLE, GREEN, YELLOW, ALLRED and EMG; at most one approach is non-red in any cycle.
REQ-014 Each state entry SHALL clear a 4-bit counter; the counter increments on tick only; a timed state ends on the tick where count==T-1, so it lasts exactly T ticks.
REQ-015 IDLE: all red; when any req bit is 1 on a clk edge, the block SHALL go to GREEN for the round-robin winner on the next clk.
REQ-016 Round robin: the winner is the first asserted req bit strictly after the last-granted index, searching upward with wrap 3->0; the last-granted index updates on GREEN/EMG entry.
REQ-017 GREEN: after GREEN_T ticks, exit to YELLOW on a tick only if some other req bit is 1; otherwise hold green (counter saturates at GREEN_T-1).
REQ-018 YELLOW: the granted approach shows 010 for YELLOW_T ticks, then goes to ALLRED.
REQ-019 ALLRED: all red for ALLRED_T ticks; then EMG if emg_req=1, else GREEN for the RR winner if any req bit is 1, else IDLE.
REQ-020 Emergency in GREEN, with a different grant: the block SHALL enter YELLOW on the next clk regardless of the counter or tick.
REQ-021 Emergency in GREEN, with grant==emg_dir: the block SHALL go to EMG without a lamp change.
REQ-022 Emergency in YELLOW/ALLRED: finish normally, then go to EMG per REQ-019.
REQ-023 Emergency in IDLE: go to EMG on the next clk.
REQ-024 EMG: green on the latched emg_dir approach and emg_active=1; hold while emg_req=1; on deassertion go to YELLOW; an emg_dir change mid-EMG SHALL be ignored.
REQ-025 Lamp and grant outputs SHALL be registered and change in the same clk as the state register.
REQ-026 req toggling within a tick interval SHALL only matter at the edge where a decision is made; no request latching.

Reset
REQ-027 While rst_n=0: state=IDLE, counter=0, last-granted=3 (M1 wins first), all lamps=100, grant=0, emg_active=0.
REQ-028 Reset asserted mid-phase SHALL force all red immediately (asynchronously), with no yellow.

Structure
REQ-029 The shared package traffic_pkg SHALL hold the lamp encodings (RED/YEL/GRN), the state enum and the approach indices (M1=0, M2=1, MT=2, SR=3).
REQ-030 Round-robin selection SHALL be one sub-module, rr_arbiter4: inputs req[3:0] and last[1:0]; outputs winner[1:0] and valid; purely combinational.
REQ-031 Target size: 150-300 lines of RTL.

Verification
REQ-032 Reset, then req=0001, tick every 4 clk: M1=001 for 7 ticks and holds (no competitor); set req=0011: M1 changes to yellow after the next tick, then yellow 2 ticks, all red 1 tick, then M2=001.
REQ-033 req=1111 held: green order M1, M2, MT, SR, M1; each green lasts exactly 7 ticks; never two non-red lamps at once.
REQ-034 M1 green at count 2, emg_req=1 with emg_dir=2: next clk M1=010, then 2 ticks yellow, 1 tick all red, then MT=001 with emg_active=1 until emg_req=0, then MT yellow.
REQ-035 MT green, emg_req=1 with emg_dir=2: no lamp change, emg_active=1 next clk; emg_dir changed to 0 mid-EMG: lamps unchanged.
REQ-036 rst_n pulled low during YELLOW: all lamps=100 within the same cycle (asynchronous); after release with req=0100: IDLE, then MT green.
REQ-037 tick held 0 for 50 clk in GREEN with competing req: no state change.
